// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the byte-wide BRAM data port.
// Sequences the memory's read timing and its read-modify-write byte-store timing.
module mem_port_arbiter #(
  parameter logic [15:0] WR_LIMIT = 16'h8000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {IDLE, ADDR, READ, WR, WHOLD, DONE} state_t;

  typedef struct packed {
    logic idx;
    logic we;
  } txn_t;

  state_t state, state_nx;
  txn_t   cur;
  logic   last_grant;
  logic   grant_en;
  logic   grant_idx;
  logic   done;
  logic   wr_err;

  always_comb begin
    state_nx  = state;
    grant_en  = 1'b0;
    // On a tie the requester that did not win last time goes first.
    grant_idx = (req0 && req1) ? ~last_grant : req1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_en = 1'b1;
          state_nx = ADDR;
        end
      end
      ADDR:    state_nx = cur.we ? WR : READ;
      READ:    state_nx = DONE;
      WR:      state_nx = WHOLD;
      WHOLD:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur        <= '0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 8'h00;
      mem_write  <= 1'b0;
      rdata0     <= 8'h00;
      rdata1     <= 8'h00;
    end else begin
      state     <= state_nx;
      mem_write <= (state_nx == WR);
      if (grant_en) begin
        last_grant <= grant_idx;
        cur        <= '{idx: grant_idx, we: (grant_idx ? we1 : we0)};
        mem_addr   <= grant_idx ? addr1 : addr0;
        mem_wdata  <= grant_idx ? wdata1 : wdata0;
      end
      if (state == READ) begin
        if (cur.idx) rdata1 <= mem_rdata;
        else         rdata0 <= mem_rdata;
      end
    end
  end

  // mem_addr holds the winner's address until DONE, so it doubles as the latched address.
  assign done   = (state == DONE);
  assign wr_err = done && cur.we && (mem_addr >= WR_LIMIT);
  assign ack0   = done && !cur.idx;
  assign ack1   = done &&  cur.idx;
  assign err0   = wr_err && !cur.idx;
  assign err1   = wr_err &&  cur.idx;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: word-wide RMW BRAM model, transaction-level reference
// model checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_mem_port_arbiter;
  localparam logic [15:0] WR_LIMIT = 16'h8000;

  logic        clock;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [7:0]  rdata0, rdata1;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;

  int n_checks = 0;
  int n_err    = 0;

  mem_port_arbiter #(.WR_LIMIT(WR_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // BRAM: 16-bit words, registered read, byte store latched on write cycle, committed next cycle.
  logic [15:0] words [0:32767];
  logic [15:0] pend;
  logic [14:0] pend_idx;
  logic        pend_v = 1'b0;
  logic        pend_ok;

  function automatic logic [15:0] merge(input logic [15:0] w, input logic hi, input logic [7:0] b);
    return hi ? {b, w[7:0]} : {w[15:8], b};
  endfunction

  initial begin
    for (int i = 0; i < 32768; i++) words[i] = 16'h0000;
  end

  always @(posedge clock) begin
    mem_rdata <= mem_addr[0] ? words[mem_addr[15:1]][15:8] : words[mem_addr[15:1]][7:0];
    if (mem_write) begin
      pend     <= merge(words[mem_addr[15:1]], mem_addr[0], mem_wdata);
      pend_idx <= mem_addr[15:1];
      pend_ok  <= (mem_addr < WR_LIMIT);
      pend_v   <= 1'b1;
    end else if (pend_v) begin
      if (pend_ok) words[pend_idx] <= pend;
      pend_v <= 1'b0;
    end
  end

  // Reference model: byte-addressed memory, countdown of cycles until ack.
  logic [7:0]  refmem [0:65535];
  int          cnt    = 0;
  bit          mlast  = 1'b1;
  bit          mwin   = 1'b0;
  logic        mw     = 1'b0;
  logic [15:0] maddr  = 16'h0000;
  logic [7:0]  mwd    = 8'h00;
  logic [7:0]  exp_rd [2];

  initial begin
    for (int i = 0; i < 65536; i++) refmem[i] = 8'h00;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt = 0; mlast = 1'b1; exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    end else if (cnt == 0) begin
      if (req0 || req1) begin
        mwin  = (req0 && req1) ? !mlast : req1;
        mlast = mwin;
        mw    = mwin ? we1 : we0;
        maddr = mwin ? addr1 : addr0;
        mwd   = mwin ? wdata1 : wdata0;
        cnt   = mw ? 4 : 3;
      end
    end else begin
      if (cnt == 2 && !mw) exp_rd[mwin] = refmem[maddr];
      if (cnt == 1 && mw && maddr < WR_LIMIT) refmem[maddr] = mwd;
      cnt = cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("ack0", ack0, cnt == 1 && !mwin);
      chk("ack1", ack1, cnt == 1 && mwin);
      chk("err0", err0, cnt == 1 && !mwin && mw && maddr >= WR_LIMIT);
      chk("err1", err1, cnt == 1 && mwin && mw && maddr >= WR_LIMIT);
      chk("rdata0", rdata0, exp_rd[0]);
      chk("rdata1", rdata1, exp_rd[1]);
      chk("mem_write", mem_write, mw && cnt == 3);
      chk("ack_exclusive", ack0 && ack1, 1'b0);
      if (cnt > 0) begin
        chk("mem_addr", mem_addr, maddr);
        chk("mem_wdata", mem_wdata, mwd);
      end
    end
  end

  task automatic issue(input int p, input logic w, input logic [15:0] a, input logic [7:0] d);
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic drop(input int p);
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic wait_ack(input int p, output int cyc, output logic [7:0] rd, output logic e);
    cyc = 0; rd = 8'h00; e = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      cyc++;
      if (p == 0 ? ack0 : ack1) begin
        rd = (p == 0) ? rdata0 : rdata1;
        e  = (p == 0) ? err0 : err1;
        return;
      end
    end
    n_checks++; n_err++;
    $display("FAIL ack timeout on port %0d at %0t", p, $time);
  endtask

  task automatic txn(input int p, input logic w, input logic [15:0] a, input logic [7:0] d,
                     input int lat, input string nm, output logic [7:0] rd, output logic e);
    int cyc;
    @(negedge clock);
    issue(p, w, a, d);
    wait_ack(p, cyc, rd, e);
    chk({nm, " latency"}, cyc, lat);
    drop(p);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0]  rd;
    logic        e;
    int          cyc;
    int          who;
    int          order [4];
    bit          busy [2];
    int          wcnt [2];
    logic [15:0] pool [9];
    pool = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0100,
             16'h7FFE, 16'h7FFF, 16'h8000, 16'hFFFF};

    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clock);
    chk("reset ack0", ack0, 0);         chk("reset ack1", ack1, 0);
    chk("reset err0", err0, 0);         chk("reset err1", err1, 0);
    chk("reset rdata0", rdata0, 8'h00); chk("reset rdata1", rdata1, 8'h00);
    chk("reset mem_addr", mem_addr, 16'h0000);
    chk("reset mem_wdata", mem_wdata, 8'h00);
    chk("reset mem_write", mem_write, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("idle mem_write", mem_write, 0);
    end

    // Byte merge: two adjacent byte writes must not clobber each other.
    txn(0, 1, 16'h0100, 8'hA5, 4, "wr A5", rd, e);
    txn(0, 1, 16'h0101, 8'h3C, 4, "wr 3C", rd, e);
    txn(0, 0, 16'h0100, 8'h00, 3, "rd 0100", rd, e);
    chk("rdata0 @0100", rd, 8'hA5);
    txn(0, 0, 16'h0101, 8'h00, 3, "rd 0101", rd, e);
    chk("rdata0 @0101", rd, 8'h3C);

    // Tie from reset: requester 0 first, then alternating.
    pulse_reset();
    issue(0, 0, 16'h0100, 8'h00);
    issue(1, 0, 16'h0101, 8'h00);
    for (int k = 0; k < 4; k++) begin
      who = -1;
      for (int i = 0; i < 30 && who < 0; i++) begin
        @(negedge clock);
        if (ack0 || ack1) who = ack1 ? 1 : 0;
      end
      order[k] = who;
      if (k >= 2 && who >= 0) drop(who);
    end
    chk("order 0", order[0], 0); chk("order 1", order[1], 1);
    chk("order 2", order[2], 0); chk("order 3", order[3], 1);
    drop(0); drop(1);

    // Write above the limit: flagged, and memory keeps its old contents.
    txn(1, 1, 16'h8000, 8'hFF, 4, "wr 8000", rd, e);
    chk("err1 on limit write", e, 1);
    txn(1, 0, 16'h8000, 8'h00, 3, "rd 8000", rd, e);
    chk("8000 not written", rd != 8'hFF, 1);
    chk("err1 on read", e, 0);

    // Reset in the write cycle aborts the store and its ack.
    @(negedge clock);
    issue(0, 1, 16'h0200, 8'h77);
    repeat (2) @(negedge clock);
    chk("mem_write in WR", mem_write, 1);
    reset = 1'b1;
    #1;
    chk("mem_write after reset", mem_write, 0);
    chk("ack0 after reset", ack0, 0);
    drop(0);
    @(negedge clock);
    reset = 1'b0;
    txn(1, 0, 16'h0200, 8'h00, 3, "rd 0200 after reset", rd, e);
    chk("0200 unwritten", rd, 8'h00);

    // New fields presented at the ack edge are granted from the following IDLE cycle.
    @(negedge clock);
    issue(0, 0, 16'h0100, 8'h00);
    wait_ack(0, cyc, rd, e);
    chk("held rd latency", cyc, 3);
    chk("held rd data", rd, 8'hA5);
    issue(0, 0, 16'h0101, 8'h00);
    wait_ack(0, cyc, rd, e);
    chk("back-to-back latency", cyc, 4);
    chk("back-to-back data", rd, 8'h3C);
    drop(0);

    // Random traffic, protocol-respecting requesters.
    busy = '{0, 0};
    wcnt = '{0, 0};
    repeat (3000) begin
      @(negedge clock);
      for (int p = 0; p < 2; p++) begin
        if (busy[p]) begin
          if (p == 0 ? ack0 : ack1) begin
            wcnt[p] = 0;
            if ($urandom_range(1) == 1)
              issue(p, 1'($urandom_range(1)), pool[$urandom_range(8)], 8'($urandom));
            else begin
              drop(p); busy[p] = 0;
            end
          end else if (++wcnt[p] > 40) begin
            n_checks++; n_err++;
            $display("FAIL random ack timeout on port %0d at %0t", p, $time);
            drop(p); busy[p] = 0; wcnt[p] = 0;
          end
        end else if ($urandom_range(2) == 0) begin
          issue(p, 1'($urandom_range(1)), pool[$urandom_range(8)], 8'($urandom));
          busy[p] = 1;
        end
      end
    end
    for (int i = 0; i < 40 && (busy[0] || busy[1]); i++) begin
      @(negedge clock);
      if (busy[0] && ack0) begin drop(0); busy[0] = 0; end
      if (busy[1] && ack1) begin drop(1); busy[1] = 0; end
    end
    if (busy[0] || busy[1]) begin
      n_checks++; n_err++;
      $display("FAIL drain timeout at %0t", $time);
    end
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
